alu_arbiter_2: RTL
==================

# alu_arbiter_2

Two-requester front end for the shared 64-bit ALU (`alu_64_bit`, instantiated inside this block). It accepts operations from two independent requesters over valid/ready handshakes and arbitrates between them round-robin. Each accepted operation goes through the ALU, and the result is registered in a single output stage with valid/ready backpressure. It sits between the execute-stage issue logic (requester 0) and the address/branch helper path (requester 1), so one ALU instance serves both.

## Interface
Parameters:
- TAG_W, 4, width of the opaque tag carried from request to response

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- r0_valid  in  1  requester 0 has an operation
- r0_ready  out  1  requester 0 operation accepted this cycle
- r0_a, r0_b  in  64  requester 0 operands
- r0_op  in  4  requester 0 ALU opcode (ALU encoding: ADD 0000, SUB 1000, SLT 0010, SLTU 0011, SLL 0001, SRL 0101, SRA 1101, AND 0111, OR 0110, XOR 0100)
- r0_tag  in  TAG_W  requester 0 tag
- r1_valid, r1_ready, r1_a, r1_b, r1_op, r1_tag  same as requester 0, for requester 1
- resp_valid  out  1  response register holds a result
- resp_ready  in  1  consumer takes the response this cycle
- resp_id  out  1  requester that issued the response (0/1)
- resp_tag  out  TAG_W  tag of the accepted request
- resp_result  out  64  ALU result
- resp_zero, resp_carry, resp_overflow  out  1  ALU zero/carry/overflow flags for that operation

## Operation
- Handshakes: a transfer occurs when valid and ready are both high at a rising edge. Requesters hold valid, operands, opcode and tag stable until ready. rX_ready may depend combinationally on rX_valid.
- can_accept = !resp_valid || resp_ready (output register empty, or draining this cycle).
- Grant: the winner is chosen combinationally among the asserted valids.
  - Only one valid: it wins.
  - Both valid: the requester not named by last_grant wins.
  - Only the winner sees ready, and only when can_accept is high. The loser's ready is 0.
- last_grant is a 1-bit register, updated to the winner's id on every accepted transfer. It is unchanged when nothing is accepted.
- The winner's a/b/op drive the internal ALU combinationally. On acceptance the response register captures:
  - result, zero, carry, overflow from the ALU
  - tag and id from the winner
- Opcodes not in the ALU encoding are accepted normally: the result is 0, carry and overflow are 0, and zero is 1.
- carry and overflow are meaningful only for ADD/SUB. The ALU drives them to 0 for all other ops, and they are passed through unchanged.
- Response register update rules:
  - accept this cycle: load the new result; resp_valid = 1
  - no accept, and resp_ready && resp_valid: resp_valid = 0; data fields hold their last value
  - otherwise: hold
- Simultaneous drain and accept in the same cycle are allowed; this gives one operation per cycle of throughput.
- Fairness: with both requesters continuously valid and resp_ready high, grants alternate strictly 0,1,0,1… (after reset the first contended grant goes to 0). Neither requester waits more than one accepted transfer behind the other.

## Timing
- Latency: a request accepted at edge N has resp_valid high in the cycle after edge N, with all resp_* fields valid.
- Throughput: 1 operation per clock while resp_ready is high.
- Backpressure: while resp_valid && !resp_ready, both rX_ready are 0, and the response fields are held stable.
- Reset (synchronous, evaluated at the edge):
  - resp_valid = 0; resp_result, resp_tag, resp_id and all flags = 0
  - last_grant = 1, so requester 0 wins the first contention
- While reset is high, rX_ready are forced to 0 and no transfer occurs.
- Reset asserted mid-operation discards any pending response. Requesters that were stalled keep their valid asserted and are served after reset deasserts, using the post-reset priority.
- The path from rX_* inputs through the ALU to the response register is a single cycle.

## Test plan
- Single ADD: r0 sends a=5, b=7, op=0000, tag=3; resp_ready=1. Expect r0_ready in the same cycle; next cycle resp_valid=1, resp_id=0, resp_tag=3, resp_result=12, resp_zero=0, resp_carry=0.
- Contention fairness: r0 and r1 are held valid for 6 cycles (r0 SUB 10−3, r1 XOR 0xF0^0x0F); resp_ready=1. Expect resp_id sequence 0,1,0,1,0,1 with results 7 and 0xFF alternating.
- Backpressure: resp_ready=0 for 3 cycles after the first response while both requesters are valid. Expect both rX_ready=0 and resp_* stable. When resp_ready returns to 1, the next transfer happens in that same cycle, and the next response appears one cycle later.
- Flags: r1 sends ADD a=0xFFFF_FFFF_FFFF_FFFF, b=1. Expect resp_result=0, resp_zero=1, resp_carry=1, resp_overflow=0. Then SUB a=0x8000_0000_0000_0000, b=1. Expect resp_result=0x7FFF_FFFF_FFFF_FFFF, resp_overflow=1.
- Shifts/compares and unsupported opcode:
  - SRA a=0x8000_0000_0000_0000, b=63 → result all ones
  - SLT a=−1, b=1 → result 1
  - SLTU a=−1, b=1 → result 0
  - op=1111 → result 0, resp_zero=1
- Reset mid-stream: assert reset while resp_valid=1 and both requesters are valid. The next cycle has resp_valid=0 and both readies 0. After deassert, the first grant goes to r0 even if r1 won last before reset.

Source files
------------

// File: rtl/alu_arbiter_2.sv
// Two-requester round-robin front end sharing one 64-bit ALU, with a single
// registered response stage under valid/ready backpressure.

module alu_64_bit (
  input  logic [63:0] a_i,
  input  logic [63:0] b_i,
  input  logic [3:0]  op_i,
  output logic [63:0] result_o,
  output logic        zero_o,
  output logic        carry_o,
  output logic        overflow_o
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b1101;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b0100;

  logic        is_sub;
  logic [63:0] b_eff;
  logic [64:0] sum;
  logic [63:0] sum_low;
  logic        lt_signed;
  logic        lt_unsigned;
  logic [5:0]  shamt;

  // SUB reuses the adder as a + ~b + 1; overflow is carry-into-msb xor carry-out.
  always_comb begin
    is_sub      = (op_i == OP_SUB);
    b_eff       = is_sub ? ~b_i : b_i;
    sum         = {1'b0, a_i} + {1'b0, b_eff} + {64'd0, is_sub};
    sum_low     = {1'b0, a_i[62:0]} + {1'b0, b_eff[62:0]} + {63'd0, is_sub};
    lt_signed   = $signed(a_i) < $signed(b_i);
    lt_unsigned = a_i < b_i;
    shamt       = b_i[5:0];
  end

  always_comb begin
    result_o   = 64'd0;
    carry_o    = 1'b0;
    overflow_o = 1'b0;
    case (op_i)
      OP_ADD, OP_SUB: begin
        result_o   = sum[63:0];
        carry_o    = sum[64];
        overflow_o = sum[64] ^ sum_low[63];
      end
      OP_SLT:  result_o = {63'd0, lt_signed};
      OP_SLTU: result_o = {63'd0, lt_unsigned};
      OP_SLL:  result_o = a_i << shamt;
      OP_SRL:  result_o = a_i >> shamt;
      OP_SRA:  result_o = $unsigned($signed(a_i) >>> shamt);
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_XOR:  result_o = a_i ^ b_i;
      default: result_o = 64'd0;
    endcase
    zero_o = (result_o == 64'd0);
  end

endmodule

module alu_arbiter_2 #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [63:0]      r0_a,
  input  logic [63:0]      r0_b,
  input  logic [3:0]       r0_op,
  input  logic [TAG_W-1:0] r0_tag,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [63:0]      r1_a,
  input  logic [63:0]      r1_b,
  input  logic [3:0]       r1_op,
  input  logic [TAG_W-1:0] r1_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [TAG_W-1:0] resp_tag,
  output logic [63:0]      resp_result,
  output logic             resp_zero,
  output logic             resp_carry,
  output logic             resp_overflow
);

  logic             resp_valid_q,    resp_valid_d;
  logic             resp_id_q,       resp_id_d;
  logic [TAG_W-1:0] resp_tag_q,      resp_tag_d;
  logic [63:0]      resp_result_q,   resp_result_d;
  logic             resp_zero_q,     resp_zero_d;
  logic             resp_carry_q,    resp_carry_d;
  logic             resp_overflow_q, resp_overflow_d;
  logic             last_grant_q,    last_grant_d;

  logic             any_valid;
  logic             win_id;
  logic             can_accept;
  logic             accept;
  logic [63:0]      alu_a;
  logic [63:0]      alu_b;
  logic [3:0]       alu_op;
  logic [TAG_W-1:0] win_tag;
  logic [63:0]      alu_result;
  logic             alu_zero;
  logic             alu_carry;
  logic             alu_overflow;

  // Contention goes to the requester that did not win last; otherwise the lone valid wins.
  always_comb begin
    any_valid  = r0_valid | r1_valid;
    win_id     = (r0_valid && r1_valid) ? ~last_grant_q : r1_valid;
    can_accept = !resp_valid_q || resp_ready;
    accept     = !reset && can_accept && any_valid;
    r0_ready   = accept && !win_id;
    r1_ready   = accept && win_id;
    alu_a      = win_id ? r1_a   : r0_a;
    alu_b      = win_id ? r1_b   : r0_b;
    alu_op     = win_id ? r1_op  : r0_op;
    win_tag    = win_id ? r1_tag : r0_tag;
  end

  alu_64_bit u_alu (
    .a_i        (alu_a),
    .b_i        (alu_b),
    .op_i       (alu_op),
    .result_o   (alu_result),
    .zero_o     (alu_zero),
    .carry_o    (alu_carry),
    .overflow_o (alu_overflow)
  );

  always_comb begin
    resp_valid_d    = resp_valid_q;
    resp_id_d       = resp_id_q;
    resp_tag_d      = resp_tag_q;
    resp_result_d   = resp_result_q;
    resp_zero_d     = resp_zero_q;
    resp_carry_d    = resp_carry_q;
    resp_overflow_d = resp_overflow_q;
    last_grant_d    = last_grant_q;
    if (accept) begin
      resp_valid_d    = 1'b1;
      resp_id_d       = win_id;
      resp_tag_d      = win_tag;
      resp_result_d   = alu_result;
      resp_zero_d     = alu_zero;
      resp_carry_d    = alu_carry;
      resp_overflow_d = alu_overflow;
      last_grant_d    = win_id;
    end else if (resp_valid_q && resp_ready) begin
      resp_valid_d    = 1'b0;
    end
  end

  // last_grant resets to 1 so requester 0 takes the first contended grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid_q    <= 1'b0;
      resp_id_q       <= 1'b0;
      resp_tag_q      <= '0;
      resp_result_q   <= 64'd0;
      resp_zero_q     <= 1'b0;
      resp_carry_q    <= 1'b0;
      resp_overflow_q <= 1'b0;
      last_grant_q    <= 1'b1;
    end else begin
      resp_valid_q    <= resp_valid_d;
      resp_id_q       <= resp_id_d;
      resp_tag_q      <= resp_tag_d;
      resp_result_q   <= resp_result_d;
      resp_zero_q     <= resp_zero_d;
      resp_carry_q    <= resp_carry_d;
      resp_overflow_q <= resp_overflow_d;
      last_grant_q    <= last_grant_d;
    end
  end

  assign resp_valid    = resp_valid_q;
  assign resp_id       = resp_id_q;
  assign resp_tag      = resp_tag_q;
  assign resp_result   = resp_result_q;
  assign resp_zero     = resp_zero_q;
  assign resp_carry    = resp_carry_q;
  assign resp_overflow = resp_overflow_q;

endmodule
